// File: rtl/parallel_cnt7.sv
// -----------------------------------------------------------------------------
// parallel_cnt7 -- 7-input population counter built as a 7:3 compressor.
//
// Computes the number of set bits in a 7-bit word combinationally, keeps a
// registered copy qualified by a valid strobe, and optionally keeps a
// saturating running total of all counted ones.
//
// Optional feature:
//   PARALLEL_CNT7_ACC_EN  when defined, compiles in the accumulator together
//                         with its acc_clr input and acc/acc_sat outputs.
//                         When undefined, those ports and logic are absent.
//
// Parameters:
//   ACC_W    accumulator width in bits, legal range 3..32 (default 16).
//
// Ports:
//   clk      in   1      clock; all state updates on the rising edge
//   rst      in   1      synchronous active-high reset
//   in       in   7      data bits to be counted
//   in_vld   in   1      qualifies in for the registered/accumulated paths
//   acc_clr  in   1      synchronous accumulator clear (ACC_EN only)
//   out      out  3      combinational population count of in
//   out_q    out  3      registered population count (loads when in_vld=1)
//   out_vld  out  1      in_vld delayed by one cycle, aligned with out_q
//   acc      out  ACC_W  saturating running sum of counted ones (ACC_EN only)
//   acc_sat  out  1      sticky saturation flag (ACC_EN only)
// -----------------------------------------------------------------------------
module parallel_cnt7 #(
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       in,
    input  logic             in_vld,
`ifdef PARALLEL_CNT7_ACC_EN
    input  logic             acc_clr,
`endif
    output logic [2:0]       out,
    output logic [2:0]       out_q,
    output logic             out_vld
`ifdef PARALLEL_CNT7_ACC_EN
    ,
    output logic [ACC_W-1:0] acc,
    output logic             acc_sat
`endif
);

    // Out-of-range widths are rejected at elaboration time.
    if (ACC_W < 3 || ACC_W > 32) begin : g_acc_w_illegal
        $error("parallel_cnt7: ACC_W must be in 3..32");
    end

    // -------------------------------------------------------------------------
    // 7:3 compressor
    //   level 1: two full adders on in[2:0] and in[5:3]  (weight-1 inputs)
    //   level 2: full adder on both level-1 sums and in[6] -> bit 0
    //   level 3: full adder on the three weight-2 carries  -> bit 1,
    //            its carry (weight 4)                      -> bit 2
    // -------------------------------------------------------------------------
    logic [1:0] w_l1_sum;
    logic [1:0] w_l1_carry;
    logic       w_l2_sum;
    logic       w_l2_carry;
    logic       w_l3_sum;
    logic       w_l3_carry;
    logic [2:0] w_cnt;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_l1_fa
            logic w_a;
            logic w_b;
            logic w_c;
            assign w_a            = in[3*gi];
            assign w_b            = in[3*gi+1];
            assign w_c            = in[3*gi+2];
            assign w_l1_sum[gi]   = w_a ^ w_b ^ w_c;
            assign w_l1_carry[gi] = (w_a & w_b) | (w_a & w_c) | (w_b & w_c);
        end
    endgenerate

    assign w_l2_sum   = w_l1_sum[0] ^ w_l1_sum[1] ^ in[6];
    assign w_l2_carry = (w_l1_sum[0] & w_l1_sum[1]) |
                        (w_l1_sum[0] & in[6])       |
                        (w_l1_sum[1] & in[6]);

    assign w_l3_sum   = w_l1_carry[0] ^ w_l1_carry[1] ^ w_l2_carry;
    assign w_l3_carry = (w_l1_carry[0] & w_l1_carry[1]) |
                        (w_l1_carry[0] & w_l2_carry)    |
                        (w_l1_carry[1] & w_l2_carry);

    assign w_cnt = {w_l3_carry, w_l3_sum, w_l2_sum};
    assign out   = w_cnt;

    // -------------------------------------------------------------------------
    // Registered count and valid
    // -------------------------------------------------------------------------
    logic [2:0] r_out_q;
    logic       r_out_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_q   <= 3'd0;
            r_out_vld <= 1'b0;
        end else begin
            r_out_vld <= in_vld;
            if (in_vld) begin
                r_out_q <= w_cnt;
            end
        end
    end

    assign out_q   = r_out_q;
    assign out_vld = r_out_vld;

`ifdef PARALLEL_CNT7_ACC_EN
    // -------------------------------------------------------------------------
    // Saturating accumulator. The sum is formed one bit wider than the
    // accumulator so the top bit flags overflow past 2^ACC_W-1.
    // -------------------------------------------------------------------------
    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    logic [ACC_W-1:0] r_acc;
    logic             r_acc_sat;
    logic [ACC_W-1:0] w_cnt_ext;
    logic [ACC_W:0]   w_acc_sum;

    assign w_cnt_ext = ACC_W'(w_cnt);
    assign w_acc_sum = {1'b0, r_acc} + {1'b0, w_cnt_ext};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_acc_sat <= 1'b0;
        end else if (acc_clr) begin
            // Clear-then-add: a valid sample on the clear cycle seeds the sum.
            r_acc     <= in_vld ? w_cnt_ext : '0;
            r_acc_sat <= 1'b0;
        end else if (in_vld) begin
            if (w_acc_sum[ACC_W]) begin
                r_acc     <= ACC_MAX;
                r_acc_sat <= 1'b1;
            end else begin
                r_acc     <= w_acc_sum[ACC_W-1:0];
            end
        end
    end

    assign acc     = r_acc;
    assign acc_sat = r_acc_sat;
`endif

endmodule

// File: tb/tb_parallel_cnt7.sv
module tb_parallel_cnt7;

`ifdef PARALLEL_CNT7_ACC_EN
    localparam int TB_ACC_W = 4;
`else
    localparam int TB_ACC_W = 16;
`endif

    logic                clk;
    logic                rst;
    logic [6:0]          in;
    logic                in_vld;
    logic [2:0]          out;
    logic [2:0]          out_q;
    logic                out_vld;
`ifdef PARALLEL_CNT7_ACC_EN
    logic                acc_clr;
    logic [TB_ACC_W-1:0] acc;
    logic                acc_sat;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [2:0]  q;
        logic        v;
        logic [31:0] a;
        logic        s;
    } exp_t;

    exp_t sb[$];

    // Reference model state
    logic [2:0]  m_q;
    logic        m_v;
    logic [31:0] m_acc;
    logic        m_sat;

    parallel_cnt7 #(
        .ACC_W   (TB_ACC_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in      (in),
        .in_vld  (in_vld),
`ifdef PARALLEL_CNT7_ACC_EN
        .acc_clr (acc_clr),
        .acc     (acc),
        .acc_sat (acc_sat),
`endif
        .out     (out),
        .out_q   (out_q),
        .out_vld (out_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] popc(input logic [6:0] d);
        return 3'($countones(d));
    endfunction

    // One clock cycle: drive inputs, check the combinational count, push the
    // model's post-edge expectation, clock, then pop and compare.
    task automatic cycle(input logic [6:0] d, input logic v, input logic c, input logic r);
        logic [32:0] sum;
        exp_t        e;
        in     = d;
        in_vld = v;
        rst    = r;
`ifdef PARALLEL_CNT7_ACC_EN
        acc_clr = c;
`endif
        #1;
        chk("out_comb", 32'(out), 32'(popc(d)));
        if (r) begin
            m_q = 3'd0; m_v = 1'b0; m_acc = 0; m_sat = 1'b0;
        end else begin
            m_v = v;
            if (v) m_q = popc(d);
            if (c) begin
                m_acc = v ? 32'(popc(d)) : 32'd0;
                m_sat = 1'b0;
            end else if (v) begin
                sum = {1'b0, m_acc} + 33'(popc(d));
                if (sum > 33'((64'd1 << TB_ACC_W) - 1)) begin
                    m_acc = 32'((64'd1 << TB_ACC_W) - 1);
                    m_sat = 1'b1;
                end else begin
                    m_acc = sum[31:0];
                end
            end
        end
        sb.push_back('{q: m_q, v: m_v, a: m_acc, s: m_sat});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("out_q", 32'(out_q), 32'(e.q));
            chk("out_vld", 32'(out_vld), 32'(e.v));
`ifdef PARALLEL_CNT7_ACC_EN
            chk("acc", 32'(acc), e.a);
            chk("acc_sat", 32'(acc_sat), 32'(e.s));
            $display("[TB] in=%0d vld=%b clr=%b rst=%b -> out_q=%0d out_vld=%b acc=%0d sat=%b",
                     d, v, c, r, out_q, out_vld, acc, acc_sat);
`else
            $display("[TB] in=%0d vld=%b rst=%b -> out_q=%0d out_vld=%b",
                     d, v, r, out_q, out_vld);
`endif
        end
    endtask

    // Combinational-only check with a fixed expected count (in_vld held low).
    task automatic comb(input string tag, input logic [6:0] d, input logic [2:0] exp);
        in = d;
        #1;
        chk(tag, 32'(out), 32'(exp));
        $display("[TB] comb in=%0d -> out=%0d", d, out);
    endtask

    initial begin
        rst = 1'b1; in = '0; in_vld = 1'b0;
`ifdef PARALLEL_CNT7_ACC_EN
        acc_clr = 1'b0;
`endif
        m_q = '0; m_v = 1'b0; m_acc = 0; m_sat = 1'b0;

        // Reset state, with the combinational path live during reset
        cycle(7'h55, 1'b1, 1'b0, 1'b1);
        cycle(7'h00, 1'b0, 1'b0, 1'b0);

        // Directed combinational values
        comb("cnt_1",   7'd1,   3'd1);
        comb("cnt_2",   7'd2,   3'd1);
        comb("cnt_3",   7'd3,   3'd2);
        comb("cnt_127", 7'd127, 3'd7);
        comb("cnt_65",  7'd65,  3'd2);
        comb("cnt_0",   7'd0,   3'd0);

        // Exhaustive sweep through the registered path (reset first so the
        // accumulator, if present, starts clean)
        cycle(7'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 128; i++) cycle(7'(i), 1'b1, 1'b0, 1'b0);

        // Register load then hold
        cycle(7'd0,   1'b0, 1'b0, 1'b1);
        cycle(7'd127, 1'b1, 1'b0, 1'b0);
        cycle(7'd3,   1'b0, 1'b0, 1'b0);
        chk("hold_q", 32'(out_q), 32'd7);
        chk("hold_vld", 32'(out_vld), 32'd0);

`ifdef PARALLEL_CNT7_ACC_EN
        // Saturation at ACC_W=4: 7, 14, 15(sat)
        cycle(7'd0,   1'b0, 1'b0, 1'b1);
        cycle(7'd127, 1'b1, 1'b0, 1'b0);
        chk("acc_7", 32'(acc), 32'd7);
        cycle(7'd127, 1'b1, 1'b0, 1'b0);
        chk("acc_14", 32'(acc), 32'd14);
        cycle(7'd127, 1'b1, 1'b0, 1'b0);
        chk("acc_15", 32'(acc), 32'd15);
        chk("sat_set", 32'(acc_sat), 32'd1);
        cycle(7'd0, 1'b1, 1'b0, 1'b0);
        chk("sat_sticky", 32'(acc_sat), 32'd1);

        // Build acc=10, then clear-then-add with in=65, then plain clear
        cycle(7'd0,   1'b0, 1'b0, 1'b1);
        cycle(7'd127, 1'b1, 1'b0, 1'b0);
        cycle(7'h07,  1'b1, 1'b0, 1'b0);
        chk("acc_10", 32'(acc), 32'd10);
        cycle(7'd65,  1'b1, 1'b1, 1'b0);
        chk("clr_add", 32'(acc), 32'd2);
        chk("clr_add_sat", 32'(acc_sat), 32'd0);
        cycle(7'd127, 1'b0, 1'b1, 1'b0);
        chk("clr_only", 32'(acc), 32'd0);
`endif

        // Mid-run reset with in_vld=1 overrides the sample
        cycle(7'd127, 1'b1, 1'b0, 1'b0);
        cycle(7'd127, 1'b1, 1'b0, 1'b0);
        cycle(7'd127, 1'b1, 1'b0, 1'b1);
        chk("rst_q", 32'(out_q), 32'd0);
        chk("rst_vld", 32'(out_vld), 32'd0);
        cycle(7'd1, 1'b1, 1'b0, 1'b0);
        chk("post_rst_q", 32'(out_q), 32'd1);

        // Random mix of valid, clear and occasional reset
        for (int i = 0; i < 200; i++) begin
            cycle(7'($urandom_range(0, 127)),
                  ($urandom_range(0, 3) != 0),
`ifdef PARALLEL_CNT7_ACC_EN
                  ($urandom_range(0, 9) == 0),
`else
                  1'b0,
`endif
                  ($urandom_range(0, 24) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
